// File: rtl/lcd_text_stream_if.sv
// lcd_text_stream_if: host write port, refresh request and the byte stream
// towards the LCD command/timing stage, bundled for lcd_text_stream.
//   wr_en/wr_addr/wr_data  host buffer write (addr 0-15 row 1, 16-31 row 2)
//   refresh_req            single-cycle request for a refresh frame
//   out_valid/out_ready    byte stream handshake
//   out_byte/out_rs        byte and its RS tag (0 = command, 1 = character)
//   busy/frame_done        frame in progress / one-cycle end-of-frame pulse
// master: host plus downstream consumer side; slave: lcd_text_stream.
interface lcd_text_stream_if;
   logic       wr_en;
   logic [4:0] wr_addr;
   logic [7:0] wr_data;
   logic       refresh_req;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_byte;
   logic       out_rs;
   logic       busy;
   logic       frame_done;

   modport master (
      output wr_en, wr_addr, wr_data, refresh_req, out_ready,
      input  out_valid, out_byte, out_rs, busy, frame_done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, refresh_req, out_ready,
      output out_valid, out_byte, out_rs, busy, frame_done
   );
endinterface

// File: rtl/lcd_text_stream.sv
// lcd_text_stream: 32-character display buffer that streams a full-screen
// refresh frame (80, row 1 chars, C0, row 2 chars) whenever it changes.
//   clk, rst_n  system clock, asynchronous active-low reset
//   bus         lcd_text_stream_if.slave: write port, refresh_req, byte
//               stream (out_valid/out_ready/out_byte/out_rs), busy, frame_done
// Parameters:
//   REFRESH_CYC  minimum idle cycles between a frame end and the next
//                dirty-triggered frame
//   FILL_CHAR    reset value of every buffer entry
module lcd_text_stream #(
   parameter int unsigned REFRESH_CYC = 5_000_000,
   parameter logic [7:0]  FILL_CHAR   = 8'h20
) (
   input logic              clk,
   input logic              rst_n,
   lcd_text_stream_if.slave bus
);

   localparam int unsigned           HOLD_W   = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
   localparam logic [HOLD_W-1:0]     HOLD_MAX = HOLD_W'(REFRESH_CYC - 1);
   localparam int unsigned           DEPTH    = 32;
   localparam logic [7:0]            CMD_ROW1 = 8'h80;
   localparam logic [7:0]            CMD_ROW2 = 8'hC0;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_R1_CMD = 3'd1;
   localparam logic [2:0] S_R1_CHR = 3'd2;
   localparam logic [2:0] S_R2_CMD = 3'd3;
   localparam logic [2:0] S_R2_CHR = 3'd4;

   logic [2:0]        state, state_d;
   logic [3:0]        col, col_d;
   logic [3:0]        col_inc;
   logic [HOLD_W-1:0] hold, hold_d;
   logic              dirty, dirty_d;
   logic              pend, pend_d;
   logic              valid_d, rs_d, busy_d, done_d;
   logic [7:0]        byte_d;
   logic              xfer;
   logic              start;
   logic [7:0]        mem [DEPTH];

   assign xfer    = bus.out_valid && bus.out_ready;
   assign col_inc = col + 4'd1;
   assign start   = (dirty && (hold == HOLD_MAX)) || pend || bus.refresh_req;

   // Display buffer; writes accepted every cycle regardless of frame state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= FILL_CHAR;
         end
      end else if (bus.wr_en) begin
         mem[bus.wr_addr] <= bus.wr_data;
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         col            <= 4'd0;
         hold           <= HOLD_MAX;
         dirty          <= 1'b1;
         pend           <= 1'b0;
         bus.out_valid  <= 1'b0;
         bus.out_byte   <= 8'h00;
         bus.out_rs     <= 1'b0;
         bus.busy       <= 1'b0;
         bus.frame_done <= 1'b0;
      end else begin
         state          <= state_d;
         col            <= col_d;
         hold           <= hold_d;
         dirty          <= dirty_d;
         pend           <= pend_d;
         bus.out_valid  <= valid_d;
         bus.out_byte   <= byte_d;
         bus.out_rs     <= rs_d;
         bus.busy       <= busy_d;
         bus.frame_done <= done_d;
      end
   end

   // Next state; the next byte is loaded on the same edge as a transfer
   always_comb begin
      state_d = state;
      col_d   = col;
      hold_d  = hold;
      dirty_d = dirty;
      pend_d  = pend;
      valid_d = bus.out_valid;
      byte_d  = bus.out_byte;
      rs_d    = bus.out_rs;
      busy_d  = bus.busy;
      done_d  = 1'b0;

      case (state)
         S_IDLE: begin
            // holdoff saturates once expired
            if (hold != HOLD_MAX) hold_d = hold + HOLD_W'(1);
            if (start) begin
               state_d = S_R1_CMD;
               byte_d  = CMD_ROW1;
               rs_d    = 1'b0;
               valid_d = 1'b1;
               busy_d  = 1'b1;
               dirty_d = 1'b0;
               pend_d  = 1'b0;
            end
         end
         S_R1_CMD: begin
            if (xfer) begin
               state_d = S_R1_CHR;
               col_d   = 4'd0;
               byte_d  = mem[5'd0];
               rs_d    = 1'b1;
            end
         end
         S_R1_CHR: begin
            if (xfer) begin
               if (col != 4'd15) begin
                  col_d  = col_inc;
                  byte_d = mem[{1'b0, col_inc}];
               end else begin
                  state_d = S_R2_CMD;
                  byte_d  = CMD_ROW2;
                  rs_d    = 1'b0;
               end
            end
         end
         S_R2_CMD: begin
            if (xfer) begin
               state_d = S_R2_CHR;
               col_d   = 4'd0;
               byte_d  = mem[5'd16];
               rs_d    = 1'b1;
            end
         end
         S_R2_CHR: begin
            if (xfer) begin
               if (col != 4'd15) begin
                  col_d  = col_inc;
                  byte_d = mem[{1'b1, col_inc}];
               end else begin
                  state_d = S_IDLE;
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  hold_d  = '0;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase

      // a request during a frame queues exactly one follow-up frame
      if (state != S_IDLE && bus.refresh_req) pend_d = 1'b1;
      // a write always wins over the clear at frame start
      if (bus.wr_en) dirty_d = 1'b1;
   end

endmodule

// File: tb/tb_lcd_text_stream.sv
// Scoreboard bench for lcd_text_stream: expected frames are built from a
// buffer model when stimulus is driven and consumed on each accepted byte.
module tb_lcd_text_stream;

   localparam int unsigned REFRESH = 100;

   logic clk = 1'b0;
   logic rst_n;
   logic ready_rand = 1'b0;

   always #5 clk = ~clk;

   lcd_text_stream_if bus ();

   lcd_text_stream #(
      .REFRESH_CYC (REFRESH),
      .FILL_CHAR   (8'h20)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks    = 0;
   int failures  = 0;
   int cyc       = 0;
   int start_cnt = 0;
   int done_cnt  = 0;
   int start_cyc = 0;
   int done_cyc  = 0;
   int acc       = 0;

   logic [8:0] sb [$];
   logic [7:0] model [32];

   logic       prev_valid = 1'b0;
   logic       prev_stall = 1'b0;
   logic       prev_done  = 1'b0;
   logic [8:0] prev_pl    = 9'd0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected 34-byte frame from the current buffer model
   function automatic void push_frame();
      sb.push_back({1'b0, 8'h80});
      for (int i = 0; i < 16; i++) sb.push_back({1'b1, model[i]});
      sb.push_back({1'b0, 8'hC0});
      for (int i = 16; i < 32; i++) sb.push_back({1'b1, model[i]});
   endfunction

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #1;
      bus.out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Output monitor, sampled mid-cycle
   always @(negedge clk) begin
      logic [8:0] pl;
      logic [8:0] exp_pl;
      pl = {bus.out_rs, bus.out_byte};
      if (bus.out_valid && !prev_valid) begin
         start_cnt++;
         start_cyc = cyc;
         acc = 0;
      end
      if (prev_stall && bus.out_valid) check("hold_stable", 32'(pl), 32'(prev_pl));
      if (bus.out_valid && bus.out_ready) begin
         check("sb_avail", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            exp_pl = sb.pop_front();
            check("byte", 32'(pl), 32'(exp_pl));
         end
         acc++;
      end
      if (bus.frame_done) begin
         check("done_pulse", 32'(prev_done), 32'd0);
         done_cnt++;
         done_cyc = cyc;
      end
      prev_done  = bus.frame_done;
      prev_valid = bus.out_valid;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_pl    = pl;
   end

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [7:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = d;
      model[a]    = d;
      sync();
      bus.wr_en   = 1'b0;
   endtask

   task automatic pulse_req();
      bus.refresh_req = 1'b1;
      sync();
      bus.refresh_req = 1'b0;
   endtask

   task automatic wait_done(input int target);
      int n = 0;
      while (done_cnt < target && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("frames_done", 32'(done_cnt), 32'(target));
   endtask

   task automatic wait_start(input int target);
      int n = 0;
      while (start_cnt < target && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("frames_started", 32'(start_cnt), 32'(target));
   endtask

   task automatic wait_acc(input int target);
      int n = 0;
      while (acc < target && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("acc_reached", 32'(acc >= target), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_byte"},  32'(bus.out_byte),  32'd0);
      check({tag, "_rs"},    32'(bus.out_rs),    32'd0);
      check({tag, "_busy"},  32'(bus.busy),      32'd0);
      check({tag, "_done"},  32'(bus.frame_done), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int d;
      rst_n           = 1'b0;
      bus.wr_en       = 1'b0;
      bus.wr_addr     = 5'd0;
      bus.wr_data     = 8'd0;
      bus.refresh_req = 1'b0;
      for (int i = 0; i < 32; i++) model[i] = 8'h20;
      #12;
      check_reset_outputs("rst");

      // first frame right after reset release, full throughput
      push_frame();
      sync();
      t0 = cyc;
      rst_n = 1'b1;
      wait_start(1);
      check("t1_start_lat", 32'(start_cyc - t0), 32'd1);
      wait_done(1);
      check("t1_frame_len", 32'(done_cyc - t0), 32'd35);
      check("t1_busy_low", 32'(bus.busy), 32'd0);
      check("t1_valid_low", 32'(bus.out_valid), 32'd0);

      // idle writes: dirty frame exactly REFRESH cycles after frame_done
      sync();
      wr(5'd0, 8'h48);
      wr(5'd1, 8'h45);
      wr(5'd2, 8'h4C);
      wr(5'd3, 8'h4C);
      wr(5'd4, 8'h4F);
      wr(5'd31, 8'h41);
      push_frame();
      wait_start(2);
      check("t2_holdoff_gap", 32'(start_cyc - done_cyc), 32'(REFRESH));
      wait_done(2);

      // refresh_req in IDLE before holdoff expiry, random backpressure
      sync();
      ready_rand = 1'b1;
      push_frame();
      t0 = cyc;
      pulse_req();
      wait_start(3);
      check("t3_req_lat", 32'(start_cyc - t0), 32'd1);
      wait_done(3);
      ready_rand = 1'b0;

      // three requests mid-frame collapse to one immediate follow-up frame
      sync();
      push_frame();
      pulse_req();
      wait_start(4);
      wait_acc(5);
      sync();
      push_frame();
      pulse_req();
      repeat (3) sync();
      pulse_req();
      repeat (2) sync();
      pulse_req();
      wait_done(4);
      d = done_cyc;
      wait_start(5);
      check("t4_pend_gap", 32'(start_cyc - d), 32'd1);
      wait_done(5);
      repeat (150) @(negedge clk);
      check("t4_no_extra", 32'(start_cnt), 32'd5);

      // write to an already loaded address: old value now, new one next frame
      sync();
      push_frame();
      pulse_req();
      wait_start(6);
      wait_acc(23);
      sync();
      wr(5'd20, 8'h5A);
      push_frame();
      wait_done(6);
      d = done_cyc;
      wait_start(7);
      check("t5_holdoff_gap", 32'(start_cyc - d), 32'(REFRESH));
      wait_done(7);

      // reset mid-frame: immediate reset values, full blank frame after release
      sync();
      push_frame();
      pulse_req();
      wait_start(8);
      wait_acc(10);
      sync();
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      sb.delete();
      for (int i = 0; i < 32; i++) model[i] = 8'h20;
      push_frame();
      repeat (2) sync();
      t0 = cyc;
      rst_n = 1'b1;
      wait_start(9);
      check("t6_start_lat", 32'(start_cyc - t0), 32'd1);
      wait_done(8);
      check("t6_frame_len", 32'(done_cyc - t0), 32'd35);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
